// File: rtl/sccomp.sv
// Single-cycle MIPS32 subset core with a preloadable instruction ROM and a debug register read port.
// Optional jal/jr support is enabled by defining SCCOMP_JUMP_EXT_EN.

module sccomp_imem #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    // Contents are supplied by hierarchical preload; the core never writes them.
    logic [DATA_W-1:0] ROM [DEPTH];

    assign data_o = ROM[addr_i];

endmodule

module sccomp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned RIDX_W   = 5;
    localparam int unsigned MEM_DEP  = 128;
    localparam int unsigned MADDR_W  = 7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [RIDX_W-1:0] RA_IDX = 5'd31;

    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] instr;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] dm_q [MEM_DEP];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              unused_shamt;

    logic [XLEN-1:0]    rs_val;
    logic [XLEN-1:0]    rt_val;
    logic [XLEN-1:0]    sext_imm;
    logic [XLEN-1:0]    zext_imm;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    addr_sum;
    logic [MADDR_W-1:0] dm_idx;
    logic [XLEN-1:0]    dm_rdata;

    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              dm_we;

    assign PC = pc_q;

    sccomp_imem #(
        .DEPTH  (MEM_DEP),
        .ADDR_W (MADDR_W),
        .DATA_W (XLEN)
    ) U_IM (
        .addr_i (PC[8:2]),
        .data_o (instr)
    );

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign imm          = instr[15:0];
    assign target       = instr[25:0];
    assign unused_shamt = ^instr[10:6];

    // Register 0 is forced to zero on every read port regardless of storage contents.
    assign rs_val   = (rs == '0) ? '0 : rf_q[rs];
    assign rt_val   = (rt == '0) ? '0 : rf_q[rt];
    assign reg_data = (reg_sel == '0) ? '0 : rf_q[reg_sel];

    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'h0000, imm};
    assign pc_plus4 = pc_q + XLEN'(4);
    assign addr_sum = rs_val + sext_imm;
    assign dm_idx   = addr_sum[8:2];
    assign dm_rdata = dm_q[dm_idx];

    // Decode, execute and next-PC selection for the instruction at PC.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        dm_we    = 1'b0;
        pc_d     = pc_plus4;

        unique case (op)
            OP_RTYPE: begin
                rf_waddr = rd;
                unique case (funct)
                    FN_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val + rt_val;
                    end
                    FN_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val - rt_val;
                    end
                    FN_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val & rt_val;
                    end
                    FN_OR: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val | rt_val;
                    end
                    FN_SLT: begin
                        rf_we    = 1'b1;
                        rf_wdata = XLEN'($signed(rs_val) < $signed(rt_val));
                    end
`ifdef SCCOMP_JUMP_EXT_EN
                    FN_JR: begin
                        pc_d = rs_val;
                    end
`endif
                    default: begin
                        rf_we = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = addr_sum;
            end
            OP_ORI: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = rs_val | zext_imm;
            end
            OP_LUI: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = {imm, 16'h0000};
            end
            OP_LW: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = dm_rdata;
            end
            OP_SW: begin
                dm_we = 1'b1;
            end
            OP_BEQ: begin
                if (rs_val == rt_val) begin
                    pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
                end
            end
            OP_J: begin
                pc_d = {pc_plus4[31:28], target, 2'b00};
            end
`ifdef SCCOMP_JUMP_EXT_EN
            OP_JAL: begin
                rf_we    = 1'b1;
                rf_waddr = RA_IDX;
                rf_wdata = pc_plus4;
                pc_d     = {pc_plus4[31:28], target, 2'b00};
            end
`endif
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

`ifndef SCCOMP_JUMP_EXT_EN
    logic unused_jump_ext;
    assign unused_jump_ext = ^{OP_JAL, FN_JR, RA_IDX};
`endif

    // PC and register file; reset clears both and overrides any pending write.
    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (rf_we && (rf_waddr != '0)) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Data memory keeps its contents across reset; stores are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!rstn && dm_we) begin
            dm_q[dm_idx] <= rt_val;
        end
    end

endmodule

// File: tb/tb_sccomp.sv
// Directed self-checking bench for sccomp: reset, ALU, immediates, memory, control flow and jal/jr option.
`timescale 1ns/1ps

module tb_sccomp;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int tests = 0;
    int fails = 0;

    sccomp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [31:0] v);
        reg_sel = idx;
        #1;
        v = reg_data;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear_rom();
        do_reset();
        tests++;
        if (dut.PC !== 32'h0) begin
            $display("FAIL reset_pc: got %h expected %h", dut.PC, 32'h0);
            fails++;
        end
        for (int i = 0; i < 32; i++) begin
            rd_reg(5'(i), v);
            tests++;
            if (v !== 32'h0) begin
                $display("FAIL reset_reg%0d: got %h expected %h", i, v, 32'h0);
                fails++;
            end
        end
    endtask

    task automatic load_alu_prog();
        clear_rom();
        dut.U_IM.ROM[0]  = itype(6'h08, 5'd0, 5'd1, 16'd5);
        dut.U_IM.ROM[1]  = itype(6'h08, 5'd0, 5'd2, 16'hFFFD);
        dut.U_IM.ROM[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        dut.U_IM.ROM[3]  = rtype(5'd2, 5'd1, 5'd4, 6'h22);
        dut.U_IM.ROM[4]  = rtype(5'd2, 5'd1, 5'd5, 6'h2A);
        dut.U_IM.ROM[5]  = rtype(5'd1, 5'd2, 5'd12, 6'h24);
        dut.U_IM.ROM[6]  = rtype(5'd1, 5'd2, 5'd13, 6'h25);
        dut.U_IM.ROM[7]  = rtype(5'd1, 5'd2, 5'd14, 6'h2A);
        dut.U_IM.ROM[8]  = rtype(5'd1, 5'd2, 5'd10, 6'h27);
        dut.U_IM.ROM[9]  = itype(6'h0A, 5'd1, 5'd11, 16'd7);
        dut.U_IM.ROM[10] = itype(6'h0F, 5'd0, 5'd15, 16'hFFFF);
        dut.U_IM.ROM[11] = itype(6'h0D, 5'd15, 5'd15, 16'hFFFF);
        dut.U_IM.ROM[12] = itype(6'h08, 5'd15, 5'd15, 16'd2);
    endtask

    task automatic test_alu();
        logic [31:0] v;
        logic [4:0]  idx [10];
        logic [31:0] exp [10];
        idx = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd12, 5'd13, 5'd14, 5'd10, 5'd11};
        exp = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'hFFFFFFF8, 32'h1,
                32'h5, 32'hFFFFFFFD, 32'h0, 32'h0, 32'h0};
        load_alu_prog();
        do_reset();
        step(13);
        tests++;
        if (dut.PC !== 32'h34) begin
            $display("FAIL alu_pc: got %h expected %h", dut.PC, 32'h34);
            fails++;
        end
        for (int i = 0; i < 10; i++) begin
            rd_reg(idx[i], v);
            tests++;
            if (v !== exp[i]) begin
                $display("FAIL alu_reg%0d: got %h expected %h", idx[i], v, exp[i]);
                fails++;
            end
        end
        rd_reg(5'd15, v);
        tests++;
        if (v !== 32'h1) begin
            $display("FAIL alu_wrap: got %h expected %h", v, 32'h1);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        load_alu_prog();
        do_reset();
        step(3);
        rstn = 1'b1;
        step(1);
        tests++;
        if (dut.PC !== 32'h0) begin
            $display("FAIL midreset_pc: got %h expected %h", dut.PC, 32'h0);
            fails++;
        end
        rd_reg(5'd1, v);
        tests++;
        if (v !== 32'h0) begin
            $display("FAIL midreset_reg1: got %h expected %h", v, 32'h0);
            fails++;
        end
        step(1);
        rstn = 1'b0;
        step(1);
        tests++;
        if (dut.PC !== 32'h4) begin
            $display("FAIL resume_pc: got %h expected %h", dut.PC, 32'h4);
            fails++;
        end
        tests++;
        if (dut.instr !== 32'h2002FFFD) begin
            $display("FAIL resume_instr: got %h expected %h", dut.instr, 32'h2002FFFD);
            fails++;
        end
        rd_reg(5'd1, v);
        tests++;
        if (v !== 32'h5) begin
            $display("FAIL resume_reg1: got %h expected %h", v, 32'h5);
            fails++;
        end
    endtask

    task automatic test_immediates();
        logic [31:0] v;
        clear_rom();
        dut.U_IM.ROM[0] = itype(6'h0F, 5'd0, 5'd6, 16'h1234);
        dut.U_IM.ROM[1] = itype(6'h0D, 5'd6, 5'd6, 16'hABCD);
        dut.U_IM.ROM[2] = itype(6'h08, 5'd0, 5'd0, 16'd7);
        dut.U_IM.ROM[3] = itype(6'h0D, 5'd0, 5'd16, 16'h8000);
        dut.U_IM.ROM[4] = itype(6'h08, 5'd0, 5'd17, 16'h8000);
        do_reset();
        step(5);
        rd_reg(5'd6, v);
        tests++;
        if (v !== 32'h1234ABCD) begin
            $display("FAIL imm_lui_ori: got %h expected %h", v, 32'h1234ABCD);
            fails++;
        end
        rd_reg(5'd0, v);
        tests++;
        if (v !== 32'h0) begin
            $display("FAIL imm_r0: got %h expected %h", v, 32'h0);
            fails++;
        end
        rd_reg(5'd16, v);
        tests++;
        if (v !== 32'h00008000) begin
            $display("FAIL imm_ori_zext: got %h expected %h", v, 32'h00008000);
            fails++;
        end
        rd_reg(5'd17, v);
        tests++;
        if (v !== 32'hFFFF8000) begin
            $display("FAIL imm_addi_sext: got %h expected %h", v, 32'hFFFF8000);
            fails++;
        end
    endtask

    task automatic test_memory();
        logic [31:0] v;
        clear_rom();
        dut.U_IM.ROM[0] = itype(6'h08, 5'd0, 5'd7, 16'h0055);
        dut.U_IM.ROM[1] = itype(6'h2B, 5'd0, 5'd7, 16'd8);
        dut.U_IM.ROM[2] = itype(6'h23, 5'd0, 5'd8, 16'd8);
        dut.U_IM.ROM[3] = itype(6'h2B, 5'd0, 5'd0, 16'd12);
        dut.U_IM.ROM[4] = itype(6'h23, 5'd0, 5'd18, 16'd10);
        dut.U_IM.ROM[5] = itype(6'h08, 5'd0, 5'd19, 16'd16);
        dut.U_IM.ROM[6] = itype(6'h23, 5'd19, 5'd20, 16'hFFF8);
        do_reset();
        step(7);
        rd_reg(5'd8, v);
        tests++;
        if (v !== 32'h55) begin
            $display("FAIL mem_lw: got %h expected %h", v, 32'h55);
            fails++;
        end
        rd_reg(5'd18, v);
        tests++;
        if (v !== 32'h55) begin
            $display("FAIL mem_byteoff: got %h expected %h", v, 32'h55);
            fails++;
        end
        rd_reg(5'd20, v);
        tests++;
        if (v !== 32'h55) begin
            $display("FAIL mem_negoff: got %h expected %h", v, 32'h55);
            fails++;
        end
        // Every word except ROM[0] becomes a store of $7 (0x55) to word 3.
        for (int i = 1; i < 128; i++) dut.U_IM.ROM[i] = itype(6'h2B, 5'd0, 5'd7, 16'd12);
        dut.U_IM.ROM[0] = itype(6'h23, 5'd0, 5'd9, 16'd12);
        rstn = 1'b1;
        step(2);
        rstn = 1'b0;
        step(1);
        rd_reg(5'd9, v);
        tests++;
        if (v !== 32'h0) begin
            $display("FAIL mem_reset_suppress: got %h expected %h", v, 32'h0);
            fails++;
        end
    endtask

    task automatic test_control();
        clear_rom();
        dut.U_IM.ROM[4] = itype(6'h04, 5'd0, 5'd0, 16'd2);
        do_reset();
        step(4);
        tests++;
        if (dut.PC !== 32'h10) begin
            $display("FAIL beq_pre_pc: got %h expected %h", dut.PC, 32'h10);
            fails++;
        end
        step(1);
        tests++;
        if (dut.PC !== 32'h1C) begin
            $display("FAIL beq_taken: got %h expected %h", dut.PC, 32'h1C);
            fails++;
        end
        clear_rom();
        dut.U_IM.ROM[0] = itype(6'h08, 5'd0, 5'd1, 16'd1);
        dut.U_IM.ROM[4] = itype(6'h04, 5'd0, 5'd1, 16'd2);
        do_reset();
        step(5);
        tests++;
        if (dut.PC !== 32'h14) begin
            $display("FAIL beq_not_taken: got %h expected %h", dut.PC, 32'h14);
            fails++;
        end
        clear_rom();
        dut.U_IM.ROM[0]  = jtype(6'h02, 26'h10);
        dut.U_IM.ROM[16] = itype(6'h04, 5'd0, 5'd0, 16'hFFFC);
        do_reset();
        step(1);
        tests++;
        if (dut.PC !== 32'h40) begin
            $display("FAIL j_target: got %h expected %h", dut.PC, 32'h40);
            fails++;
        end
        step(1);
        tests++;
        if (dut.PC !== 32'h34) begin
            $display("FAIL beq_backward: got %h expected %h", dut.PC, 32'h34);
            fails++;
        end
    endtask

    task automatic test_jump_ext();
        logic [31:0] v;
        logic [31:0] exp_pc1;
        logic [31:0] exp_ra;
        logic [31:0] exp_pc2;
`ifdef SCCOMP_JUMP_EXT_EN
        exp_pc1 = 32'h40;
        exp_ra  = 32'h24;
        exp_pc2 = 32'h24;
`else
        exp_pc1 = 32'h24;
        exp_ra  = 32'h0;
        exp_pc2 = 32'h28;
`endif
        clear_rom();
        dut.U_IM.ROM[8]  = jtype(6'h03, 26'h10);
        dut.U_IM.ROM[9]  = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        dut.U_IM.ROM[16] = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        do_reset();
        step(9);
        tests++;
        if (dut.PC !== exp_pc1) begin
            $display("FAIL jal_pc: got %h expected %h", dut.PC, exp_pc1);
            fails++;
        end
        rd_reg(5'd31, v);
        tests++;
        if (v !== exp_ra) begin
            $display("FAIL jal_ra: got %h expected %h", v, exp_ra);
            fails++;
        end
        step(1);
        tests++;
        if (dut.PC !== exp_pc2) begin
            $display("FAIL jr_pc: got %h expected %h", dut.PC, exp_pc2);
            fails++;
        end
    endtask

    initial begin
        rstn    = 1'b1;
        reg_sel = 5'd0;
        test_reset();
        test_alu();
        test_reset_mid();
        test_immediates();
        test_memory();
        test_control();
        test_jump_ext();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sccomp.md
SCCOMP -- requirements
Module: sccomp

Interface
REQ-001 SHALL provide clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide rstn  input  1  reset, synchronous and active-high (asserted when 1, sampled on rising clk).
REQ-003 SHALL provide reg_sel  input  5  register-file debug read index.
REQ-004 SHALL provide reg_data  output  32  combinational contents of register reg_sel.
REQ-005 SHALL expose internal nets PC (32 bits, current fetch address) and instr (32 bits, fetched word) at top level for hierarchical probing.
REQ-006 SHALL contain instruction memory instance U_IM holding array ROM of 128 x 32-bit words, loadable by hierarchical preload; no write port.

Function
REQ-007 SHALL execute one MIPS32 instruction per clk cycle (single-cycle datapath, no pipeline, no stalls).
REQ-008 SHALL fetch instr = ROM[PC[8:2]] combinationally; PC[1:0] ignored; addresses above 0x1FC alias.
REQ-009 SHALL support R-type add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A) writing rd.
REQ-010 SHALL support addi, ori, lui, lw, sw, beq, j (opcodes 0x08, 0x0D, 0x0F, 0x23, 0x2B, 0x04, 0x02).
REQ-011 SHALL sign-extend immediates for addi, lw, sw, beq; zero-extend for ori; lui writes {imm,16'h0}.
REQ-012 SHALL wrap add/sub/addi modulo 2^32; no overflow exception.
REQ-013 SHALL compute slt as signed comparison, result 0 or 1.
REQ-014 SHALL provide 32 x 32-bit register file, two combinational read ports plus debug port, one write port on rising clk; register 0 always reads 0, writes ignored.
REQ-015 SHALL provide 128 x 32-bit data memory, word address addr[8:2], combinational read, write on rising clk for sw; byte offset ignored.
REQ-016 SHALL update PC each cycle: PC+4 default; beq taken -> PC+4+(sext(imm)<<2); j -> {PC+4[31:28], target, 2'b00}.
REQ-017 SHALL treat any unsupported opcode/funct (including all-zero word) as NOP: no register/memory write, PC+4.
REQ-018 SHALL make debug read bypass-free: reg_data reflects value after the most recent completed write edge.

Reset
REQ-019 SHALL, on rising clk with rstn=1, set PC to 0x00000000 and clear all 32 registers to 0.
REQ-020 SHALL suppress all register and data-memory writes in any cycle where rstn=1.
REQ-021 SHALL leave data memory and ROM contents unchanged by reset.
REQ-022 SHALL resume fetch from 0x00000000 on first rising clk after rstn returns to 0, including reset asserted mid-program.

Configuration
REQ-023 SHALL, when macro SCCOMP_JUMP_EXT_EN is defined, additionally support jal (opcode 0x03: $31 <= PC+4, jump as j) and jr (R-type funct 0x08: PC <= rs).
REQ-024 SHALL, without SCCOMP_JUMP_EXT_EN, treat jal and jr as NOP per REQ-017.

Verification
REQ-025 Reset: hold rstn=1 two cycles, release -> PC=0x00000000, reg_data=0 for every reg_sel.
REQ-026 ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1 -> regs 3,4,5 = 0x2, 0xFFFFFFF8, 0x1.
REQ-027 Immediates: lui $6,0x1234; ori $6,$6,0xABCD; addi $0,$0,7 -> $6=0x1234ABCD, $0=0.
REQ-028 Memory: addi $7,$0,0x55; sw $7,8($0); lw $8,8($0) -> $8=0x00000055.
REQ-029 Control: beq taken at PC 0x10 offset 2 -> next PC 0x1C; not taken -> 0x14; j target 0x10 -> PC 0x40.
REQ-030 Config: jal at 0x20 with SCCOMP_JUMP_EXT_EN -> $31=0x24, jr $31 returns to 0x24; without macro both advance PC by 4, $31 unchanged.
